pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives write-enable and flush of the IF/ID, ID/EX and EX/MEM pipeline registers, plus PC write and PC source select.
- Inserts load-use bubbles, squashes wrong-path instructions on branch/jump resolved in MEM, and freezes the pipe while data memory is not ready.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- LOAD_BUBBLES, 1, bubbles per load-use hazard (1 with forwarding, 2 without); legal range 1..3.
- CNT_W, 16, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- if_id_rs  in  REG_ADDR_W  rs of instruction in ID.
- if_id_rt  in  REG_ADDR_W  rt of instruction in ID.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_ADDR_W  load destination in EX.
- mem_branch_taken  in  1  EX/MEM branch with Zero condition met.
- mem_jump  in  1  EX/MEM holds a jump.
- mem_req  in  1  EX/MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC update enable.
- pc_src  out  2  00 PC_4, 01 BranchAddress, 10 JumpAddress.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  IF/ID clear to NOP.
- id_ex_write  out  1  ID/EX enable.
- id_ex_flush  out  1  ID/EX clear to bubble.
- ex_mem_write  out  1  EX/MEM enable.
- ex_mem_flush  out  1  EX/MEM clear.
- stall_state  out  2  current FSM state, for debug.

Behaviour:
- Reset: synchronous, sampled on rising clk while reset==0. FSM goes to RESET_HOLD and bubble_cnt to 0.
- RESET_HOLD outputs (the reset values): all *_write=0, all *_flush=1, pc_src=00, stall_state=00.
- First rising edge with reset==1: RESET_HOLD -> RUN.
- States: RESET_HOLD(00), RUN(01), LOAD_STALL(10), MEM_WAIT(11).
- Outputs are combinational from state and inputs. State and bubble_cnt are registered.
- Hazard = id_ex_mem_read && id_ex_rt!=0 && (id_ex_rt==if_id_rs || id_ex_rt==if_id_rt).
- MemStall = mem_req && !mem_ready.
- Redirect = mem_branch_taken || mem_jump.
- Priority, highest first: MemStall > Redirect > Hazard.
- MemStall, in any non-reset state:
  - All *_write=0 and all *_flush=0 (freeze); pc_write=0.
  - Next state MEM_WAIT; bubble_cnt is held.
- MEM_WAIT exit: on mem_ready=1 the cycle behaves as RUN.
  - Next state RUN, or LOAD_STALL if bubble_cnt!=0 (resume an interrupted load stall).
- Redirect (no MemStall):
  - pc_write=1, pc_src=10 if mem_jump else 01 (jump wins if both are set).
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1; all *_write=1.
  - bubble_cnt cleared, next state RUN.
  - A pending load stall is cancelled because the load is squashed.
- Hazard in RUN (no MemStall, no Redirect):
  - pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1.
  - bubble_cnt=LOAD_BUBBLES-1.
  - Next state LOAD_STALL if LOAD_BUBBLES>1, else RUN.
- LOAD_STALL: same outputs as the Hazard case.
  - Each cycle bubble_cnt decrements; at 0 -> RUN.
  - The hazard term is not re-evaluated in LOAD_STALL.
- RUN with no event: every *_write=1, every *_flush=0, pc_write=1, pc_src=00.
- Flush and write are never both active on the same register except in the Redirect and reset cases. Flush overrides write.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With it defined, three outputs are added, each CNT_W wide and saturating at all-ones:
  - perf_stall_cycles: counts cycles in LOAD_STALL plus Hazard-in-RUN cycles.
  - perf_mem_wait_cycles: counts MemStall cycles.
  - perf_flush_count: counts Redirect events.
  - All three clear on reset.
- Without it, these ports and their logic are absent, and core behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - State encoding constants HZ_RESET_HOLD, HZ_RUN, HZ_LOAD_STALL, HZ_MEM_WAIT.
  - PC source constants PCSRC_PC4=2'b00, PCSRC_BRANCH=2'b01, PCSRC_JUMP=2'b10.
- One natural sub-module: hazard_detect_unit, purely combinational, computing Hazard from the register specifiers. FSM and counters stay in the top module.

Test Plan:
- Reset low 3 cycles, then high: during reset all writes=0 and flushes=1. Cycle after release: stall_state=01, all writes=1, pc_src=00.
- id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5, LOAD_BUBBLES=2: exactly 2 cycles of pc_write=0, if_id_write=0, id_ex_flush=1, then RUN. Repeat with rt=0: no stall.
- mem_req=1, mem_ready=0 for 4 cycles, then 1: 4 cycles of all writes=0 with no flush; state 11; release cycle writes=1.
- mem_branch_taken=1 and mem_jump=1 together: pc_src=10, three flushes=1 for 1 cycle. Same cycle with Hazard active: no stall is inserted.
- Load stall (LOAD_BUBBLES=3) interrupted by MemStall after 1 bubble: freeze, then exactly 2 further bubbles. Redirect mid-stall: stall cancelled.
- With HAZARD_PERF_CNT_EN, CNT_W=4 and 20 MemStall cycles: perf_mem_wait_cycles saturates at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control logic.
// Holds the hazard sequencer state encoding, PC source codes and the
// pipeline-control bundle with one constructor per control pattern.
package mips_pkg;

    typedef enum logic [1:0] {
        HZ_RESET_HOLD = 2'b00,
        HZ_RUN        = 2'b01,
        HZ_LOAD_STALL = 2'b10,
        HZ_MEM_WAIT   = 2'b11
    } hz_state_e;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One complete set of pipeline-register and PC controls.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       if_id_write;
        logic       if_id_flush;
        logic       id_ex_write;
        logic       id_ex_flush;
        logic       ex_mem_write;
        logic       ex_mem_flush;
    } hz_ctrl_t;

    // Reset hold: nothing advances, every register is cleared.
    function automatic hz_ctrl_t ctrl_reset();
        return '{pc_write: 1'b0, pc_src: PCSRC_PC4,
                 if_id_write: 1'b0, if_id_flush: 1'b1,
                 id_ex_write: 1'b0, id_ex_flush: 1'b1,
                 ex_mem_write: 1'b0, ex_mem_flush: 1'b1};
    endfunction

    // Normal flow: every stage advances, sequential PC.
    function automatic hz_ctrl_t ctrl_run();
        return '{pc_write: 1'b1, pc_src: PCSRC_PC4,
                 if_id_write: 1'b1, if_id_flush: 1'b0,
                 id_ex_write: 1'b1, id_ex_flush: 1'b0,
                 ex_mem_write: 1'b1, ex_mem_flush: 1'b0};
    endfunction

    // Memory not ready: the whole pipe holds its contents.
    function automatic hz_ctrl_t ctrl_freeze();
        return '0;
    endfunction

    // Load-use bubble: IF and ID hold, a bubble enters EX, EX/MEM drains.
    function automatic hz_ctrl_t ctrl_bubble();
        return '{pc_write: 1'b0, pc_src: PCSRC_PC4,
                 if_id_write: 1'b0, if_id_flush: 1'b0,
                 id_ex_write: 1'b0, id_ex_flush: 1'b1,
                 ex_mem_write: 1'b1, ex_mem_flush: 1'b0};
    endfunction

    // Taken branch or jump in MEM: redirect the PC, squash the wrong path.
    // A jump wins when both are flagged.
    function automatic hz_ctrl_t ctrl_redirect(input logic is_jump);
        return '{pc_write: 1'b1, pc_src: (is_jump ? PCSRC_JUMP : PCSRC_BRANCH),
                 if_id_write: 1'b1, if_id_flush: 1'b1,
                 id_ex_write: 1'b1, id_ex_flush: 1'b1,
                 ex_mem_write: 1'b1, ex_mem_flush: 1'b1};
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector: flags an instruction in ID that reads the
// destination of a load currently in EX. Register $0 never creates a hazard.
module hazard_detect_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    output logic                  hazard
);

    // Compare the load destination against both ID source specifiers.
    always_comb begin
        hazard = id_ex_mem_read && (id_ex_rt != '0) &&
                 ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Priority per cycle: memory stall > branch/jump redirect > load-use hazard.
// LOAD_BUBBLES is legal in 1..3 (1 with forwarding, 2 without).
// Optional macro HAZARD_PERF_CNT_EN adds three saturating perf counters.
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_BUBBLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic                  mem_branch_taken,
    input  logic                  mem_jump,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write,
    output logic                  ex_mem_flush,
    output logic [1:0]            stall_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_mem_wait_cycles,
    output logic [CNT_W-1:0]      perf_flush_count
`endif
);

    // Bubbles still owed after the one issued on hazard detection.
    localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_BUBBLES - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] bubble_cnt_q, bubble_cnt_d;
    hz_ctrl_t   ctrl;
    logic       hazard;
    logic       mem_stall;
    logic       redirect;
    logic       bubble_evt;    // a load-use bubble is issued this cycle
    logic       redirect_evt;  // a redirect is performed this cycle
    logic       mem_wait_evt;  // the pipe is frozen on memory this cycle

    hazard_detect_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .hazard         (hazard)
    );

    // Next-state, bubble counter and control outputs in priority order.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        state_d      = state_q;
        bubble_cnt_d = bubble_cnt_q;
        ctrl         = ctrl_reset();
        bubble_evt   = 1'b0;
        redirect_evt = 1'b0;
        mem_wait_evt = 1'b0;
        mem_stall    = mem_req && !mem_ready;
        redirect     = mem_branch_taken || mem_jump;

        if (state_q == HZ_RESET_HOLD) begin
            state_d = HZ_RUN;
        end else if (mem_stall) begin
            ctrl         = ctrl_freeze();
            mem_wait_evt = 1'b1;
            state_d      = HZ_MEM_WAIT;
        end else if (redirect) begin
            // The squashed load no longer needs its pending bubbles.
            ctrl         = ctrl_redirect(mem_jump);
            redirect_evt = 1'b1;
            bubble_cnt_d = '0;
            state_d      = HZ_RUN;
        end else if (state_q == HZ_LOAD_STALL) begin
            // The hazard term is ignored here: the stall just runs its count down.
            ctrl         = ctrl_bubble();
            bubble_evt   = 1'b1;
            bubble_cnt_d = bubble_cnt_q - 2'd1;
            state_d      = (bubble_cnt_q <= 2'd1) ? HZ_RUN : HZ_LOAD_STALL;
        end else if (hazard) begin
            ctrl         = ctrl_bubble();
            bubble_evt   = 1'b1;
            bubble_cnt_d = BUBBLE_INIT;
            state_d      = (LOAD_BUBBLES > 1) ? HZ_LOAD_STALL : HZ_RUN;
        end else begin
            // RUN, or the release cycle of MEM_WAIT; a load stall cut short
            // by the memory freeze resumes with its remaining bubbles.
            ctrl    = ctrl_run();
            state_d = (bubble_cnt_q != '0) ? HZ_LOAD_STALL : HZ_RUN;
        end
    end

    // State and bubble counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q      <= HZ_RESET_HOLD;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign pc_src       = ctrl.pc_src;
    assign if_id_write  = ctrl.if_id_write;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_write  = ctrl.id_ex_write;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_write = ctrl.ex_mem_write;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign stall_state  = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_mem_q,   perf_mem_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    // Saturating increments: a counter stops at all-ones.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_mem_d   = perf_mem_q;
        perf_flush_d = perf_flush_q;
        if (bubble_evt && (perf_stall_q != '1))   perf_stall_d = perf_stall_q + 1'b1;
        if (mem_wait_evt && (perf_mem_q != '1))   perf_mem_d   = perf_mem_q + 1'b1;
        if (redirect_evt && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 1'b1;
    end

    // Perf counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_mem_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_mem_q   <= perf_mem_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles    = perf_stall_q;
    assign perf_mem_wait_cycles = perf_mem_q;
    assign perf_flush_count     = perf_flush_q;
`endif

endmodule
